// File: rtl/rank_change_logger_pkg.sv
// Shared types and constants for the rank change logger.
//   rank_evt_t  : default event layout {tracked value, sample timestamp}
//   DROP_CNT_W  : width of the saturating dropped-event counter
package rank_log_pkg;

   localparam int EVT_DATA_W = 32;
   localparam int EVT_TS_W   = 16;

   typedef struct packed {
      logic [EVT_DATA_W-1:0] data;
      logic [EVT_TS_W-1:0]   ts;
   } rank_evt_t;

   localparam int DROP_CNT_W = 8;
   localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/rank_change_logger_evt_fifo.sv
// Synchronous event FIFO with first-word-fall-through head.
//   clk, resetn : clock, synchronous active-low reset
//   push, din   : write an entry (ignored when full unless popping in the same cycle)
//   pop         : remove the head entry (ignored when empty)
//   dout        : head entry, forced to zero while empty
//   full, empty : occupancy flags
module evt_fifo #(
   parameter int WIDTH = 48,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // When full, the slot being written is the head being popped this cycle.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Zeroing the head while empty keeps stale storage invisible after reset.
   assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rank_change_logger.sv
// Logs changes of the second-largest tracker output with a sample-count
// timestamp and streams them out through a small FIFO.
//   clk, resetn         : clock, synchronous active-low reset
//   in_valid, rank_in   : tracker sample stream
//   clr_ovf             : clears overflow and drop_cnt (a same-cycle drop wins)
//   out_valid/out_ready : event stream handshake
//   out_data, out_ts    : head event value and the sample index it changed at
//   overflow, drop_cnt  : sticky drop flag and saturating drop count
module rank_change_logger
   import rank_log_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int TS_WIDTH   = 16,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] rank_in,
   input  logic                  clr_ovf,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [TS_WIDTH-1:0]   out_ts,
   output logic                  overflow,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam int EVT_W = DATA_WIDTH + TS_WIDTH;

   logic [DATA_WIDTH-1:0] prev;
   logic [TS_WIDTH-1:0]   ts_cnt;
   logic                  chg;
   logic                  push;
   logic                  pop;
   logic                  drop;
   logic                  full;
   logic                  empty;
   logic [EVT_W-1:0]      head;

   assign chg  = in_valid && (rank_in != prev);
   assign pop  = out_valid && out_ready;
   assign push = chg && (!full || pop);
   assign drop = chg && full && !pop;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         prev     <= '0;
         ts_cnt   <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         // prev follows every sample so a dropped change is not re-reported.
         if (in_valid) begin
            prev   <= rank_in;
            ts_cnt <= ts_cnt + 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
            if (clr_ovf)
               drop_cnt <= DROP_CNT_W'(1);
            else if (drop_cnt != DROP_CNT_MAX)
               drop_cnt <= drop_cnt + 1'b1;
         end else if (clr_ovf) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
         end
      end
   end

   evt_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .pop    (pop),
      .din    ({rank_in, ts_cnt}),
      .dout   (head),
      .full   (full),
      .empty  (empty)
   );

   assign out_valid = !empty;
   assign out_data  = head[EVT_W-1 -: DATA_WIDTH];
   assign out_ts    = head[TS_WIDTH-1:0];

endmodule
